// File: rtl/trig_config_sequencer.sv
// Shadow/active sequencer for the per-L4 pretrigger and delay settings of trigger_handling_v2.
// A commit disables the trigger processor, drains L4 activity, swaps shadow->active, settles, releases.
module trig_config_sequencer #(
    parameter int NUM_L4        = 5,
    parameter int PRETRG_BITS   = 8,
    parameter int DELAY_BITS    = 4,
    parameter int DRAIN_CYCLES  = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          wr_i,
    input  logic                          sel_i,
    input  logic [3:0]                    idx_i,
    input  logic [7:0]                    data_i,
    input  logic                          commit_i,
    input  logic                          sw_disable_i,
    input  logic [NUM_L4-1:0]             l4_i,
    output logic [NUM_L4*PRETRG_BITS-1:0] pretrigger_vector_o,
    output logic [NUM_L4*DELAY_BITS-1:0]  delay_vector_o,
    output logic                          disable_o,
    output logic                          disable_ce_o,
    output logic                          busy_o,
    output logic                          done_o
);

    localparam int PRE_W   = NUM_L4 * PRETRG_BITS;
    localparam int DLY_W   = NUM_L4 * DELAY_BITS;
    localparam int CNT_MAX = (DRAIN_CYCLES > SETTLE_CYCLES) ? DRAIN_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SETTLE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pending_q, pending_d;
    logic               target_q, target_d;
    logic               swap_q, swap_d;
    logic               rel_q, rel_d;
    logic [PRE_W-1:0]   pre_sh_q, pre_sh_d;
    logic [DLY_W-1:0]   dly_sh_q, dly_sh_d;
    logic [PRE_W-1:0]   pre_act_q, pre_act_d;
    logic [DLY_W-1:0]   dly_act_q, dly_act_d;
    logic               disable_q, disable_d;
    logic               disable_ce_q, disable_ce_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // The FSM decides target/swap/release one cycle ahead; the output flops
    // below present those decisions, so every port is a plain register.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pending_d    = pending_q;
        target_d     = target_q;
        swap_d       = 1'b0;
        rel_d        = 1'b0;
        pre_sh_d     = pre_sh_q;
        dly_sh_d     = dly_sh_q;
        pre_act_d    = pre_act_q;
        dly_act_d    = dly_act_q;
        disable_d    = target_q;
        disable_ce_d = (target_q != disable_q);
        busy_d       = (state_q != ST_IDLE);
        done_d       = rel_q;

        for (int i = 0; i < NUM_L4; i++) begin
            if (wr_i && (idx_i == i[3:0])) begin
                if (sel_i) begin
                    dly_sh_d[i*DELAY_BITS +: DELAY_BITS] = data_i[DELAY_BITS-1:0];
                end else begin
                    pre_sh_d[i*PRETRG_BITS +: PRETRG_BITS] = data_i[PRETRG_BITS-1:0];
                end
            end
        end

        // Swap uses the registered shadow, so a write on the swap edge waits for the next commit.
        if (swap_q) begin
            pre_act_d = pre_sh_q;
            dly_act_d = dly_sh_q;
        end

        case (state_q)
            ST_IDLE: begin
                target_d = sw_disable_i;
                if (commit_i) begin
                    state_d  = ST_DRAIN;
                    cnt_d    = CNT_W'(DRAIN_CYCLES - 1);
                    target_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                target_d  = 1'b1;
                pending_d = pending_q | commit_i;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (l4_i == '0) begin
                    swap_d  = 1'b1;
                    state_d = ST_SETTLE;
                    cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                end
            end
            ST_SETTLE: begin
                target_d  = 1'b1;
                pending_d = pending_q | commit_i;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    rel_d = 1'b1;
                    if (pending_q || commit_i) begin
                        pending_d = 1'b0;
                        state_d   = ST_DRAIN;
                        cnt_d     = CNT_W'(DRAIN_CYCLES - 1);
                    end else begin
                        state_d  = ST_IDLE;
                        target_d = sw_disable_i;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                target_d = sw_disable_i;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            pending_q    <= 1'b0;
            target_q     <= 1'b0;
            swap_q       <= 1'b0;
            rel_q        <= 1'b0;
            pre_sh_q     <= '0;
            dly_sh_q     <= '0;
            pre_act_q    <= '0;
            dly_act_q    <= '0;
            disable_q    <= 1'b0;
            disable_ce_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            target_q     <= target_d;
            swap_q       <= swap_d;
            rel_q        <= rel_d;
            pre_sh_q     <= pre_sh_d;
            dly_sh_q     <= dly_sh_d;
            pre_act_q    <= pre_act_d;
            dly_act_q    <= dly_act_d;
            disable_q    <= disable_d;
            disable_ce_q <= disable_ce_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign pretrigger_vector_o = pre_act_q;
    assign delay_vector_o      = dly_act_q;
    assign disable_o           = disable_q;
    assign disable_ce_o        = disable_ce_q;
    assign busy_o              = busy_q;
    assign done_o              = done_q;

endmodule

// File: tb/tb_trig_config_sequencer.sv
// Directed bench for trig_config_sequencer: commit timing, L4 stall, commit collapsing,
// swap-edge writes, software disable and mid-sequence reset, with a done-time vector scoreboard.
module tb_trig_config_sequencer;

    localparam int N  = 5;
    localparam int PB = 8;
    localparam int DB = 4;
    localparam int VW = N*PB + N*DB;

    logic           clk = 1'b0;
    logic           rst_i = 1'b1;
    logic           wr_i = 1'b0;
    logic           sel_i = 1'b0;
    logic [3:0]     idx_i = '0;
    logic [7:0]     data_i = '0;
    logic           commit_i = 1'b0;
    logic           sw_disable_i = 1'b0;
    logic [N-1:0]   l4_i = '0;
    logic [N*PB-1:0] pretrigger_vector_o;
    logic [N*DB-1:0] delay_vector_o;
    logic           disable_o, disable_ce_o, busy_o, done_o;

    int errors = 0;
    int checks = 0;
    int e = 0;
    int ce_cnt, done_n, done1, done2, first_low;

    logic [VW-1:0] exp_q[$];
    logic [PB-1:0] m_pre[N];
    logic [DB-1:0] m_dly[N];

    trig_config_sequencer dut (
        .clk_i(clk), .rst_i(rst_i), .wr_i(wr_i), .sel_i(sel_i), .idx_i(idx_i),
        .data_i(data_i), .commit_i(commit_i), .sw_disable_i(sw_disable_i), .l4_i(l4_i),
        .pretrigger_vector_o(pretrigger_vector_o), .delay_vector_o(delay_vector_o),
        .disable_o(disable_o), .disable_ce_o(disable_ce_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] model_pack();
        logic [N*PB-1:0] p;
        logic [N*DB-1:0] d;
        for (int i = 0; i < N; i++) begin
            p[i*PB +: PB] = m_pre[i];
            d[i*DB +: DB] = m_dly[i];
        end
        return {p, d};
    endfunction

    // Scoreboard: each completed sequence must present the vectors predicted at commit.
    always @(negedge clk) begin
        if (done_o === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL done_unexpected: observed=done with empty queue expected=no done");
            end
            if (exp_q.size() != 0) begin
                logic [VW-1:0] ev;
                ev = exp_q.pop_front();
                check("done_vectors", {pretrigger_vector_o, delay_vector_o}, ev);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        e++;
        if (disable_ce_o === 1'b1) ce_cnt++;
        if (done_o === 1'b1) begin
            done_n++;
            if (done_n == 1) done1 = e;
            else if (done_n == 2) done2 = e;
        end
        if (disable_o !== 1'b1 && first_low == 0) first_low = e;
    endtask

    task automatic run_to(input int t);
        while (e < t) tick();
    endtask

    task automatic write(input logic s, input logic [3:0] idx, input logic [7:0] d);
        wr_i = 1'b1; sel_i = s; idx_i = idx; data_i = d;
        tick();
        wr_i = 1'b0;
        if (idx < N) begin
            if (s) m_dly[idx] = d[DB-1:0];
            else   m_pre[idx] = d[PB-1:0];
        end
    endtask

    // Returns right after edge 0, the edge that samples commit_i.
    task automatic commit_now();
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        e = 0; ce_cnt = 0; done_n = 0; done1 = 0; done2 = 0; first_low = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pre[i] = '0;
            m_dly[i] = '0;
        end
    endtask

    initial begin
        model_reset();
        // Reset state
        tick(); tick();
        check("rst_disable", disable_o, 0);
        check("rst_ce", disable_ce_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_vectors", {pretrigger_vector_o, delay_vector_o}, 0);
        rst_i = 1'b0;
        tick();

        // Basic commit: pre[0]=53, dly[1]=3
        write(0, 4'd0, 8'd53);
        write(1, 4'd1, 8'd3);
        exp_q.push_back(model_pack());
        commit_now();
        check("t1_e0_disable", disable_o, 0);
        tick();
        check("t1_e1_disable", disable_o, 1);
        check("t1_e1_ce", disable_ce_o, 1);
        check("t1_e1_busy", busy_o, 1);
        run_to(16);
        check("t1_e16_pre", pretrigger_vector_o[7:0], 0);
        check("t1_e16_dly", delay_vector_o[7:4], 0);
        tick();
        check("t1_e17_pre", pretrigger_vector_o[7:0], 53);
        check("t1_e17_dly", delay_vector_o[7:4], 3);
        run_to(20);
        check("t1_e20_done", done_o, 0);
        tick();
        check("t1_e21_done", done_o, 1);
        check("t1_e21_disable", disable_o, 0);
        check("t1_e21_ce", disable_ce_o, 1);
        check("t1_e21_busy", busy_o, 0);
        tick(); tick();

        // L4 activity stalls the swap; l4_i first samples as 0 at edge 25
        write(0, 4'd3, 8'h77);
        exp_q.push_back(model_pack());
        l4_i = 5'b00011;
        commit_now();
        run_to(24);
        l4_i = '0;
        tick();
        check("t2_e25_pre3_old", pretrigger_vector_o[31:24], 0);
        tick();
        check("t2_e26_pre3_new", pretrigger_vector_o[31:24], 8'h77);
        run_to(29);
        check("t2_e29_done", done_o, 0);
        tick();
        check("t2_e30_done", done_o, 1);
        check("t2_first_low", first_low, 30);
        tick(); tick();

        // Write on the swap edge keeps the old active value
        write(0, 4'd1, 8'h11);
        exp_q.push_back(model_pack());
        commit_now();
        run_to(16);
        wr_i = 1'b1; sel_i = 1'b0; idx_i = 4'd2; data_i = 8'd9;
        tick();
        wr_i = 1'b0;
        m_pre[2] = 8'd9;
        check("t4_e17_pre2_old", pretrigger_vector_o[23:16], 0);
        check("t4_e17_pre1_new", pretrigger_vector_o[15:8], 8'h11);
        run_to(21);
        check("t4_done1", done1, 21);
        tick();
        write(0, 4'd7, 8'hFF);
        write(1, 4'd7, 8'hFF);
        write(0, 4'd5, 8'hEE);
        exp_q.push_back(model_pack());
        commit_now();
        run_to(21);
        check("t4_next_pre2", pretrigger_vector_o[23:16], 9);
        check("t4_next_done", done1, 21);
        tick(); tick();

        // Commits at edges 0, 5, 10 collapse into two sequences
        exp_q.push_back(model_pack());
        exp_q.push_back(model_pack());
        commit_now();
        run_to(4);
        commit_i = 1'b1; tick(); commit_i = 1'b0;
        run_to(9);
        commit_i = 1'b1; tick(); commit_i = 1'b0;
        run_to(45);
        check("t3_done_count", done_n, 2);
        check("t3_done1", done1, 21);
        check("t3_done2", done2, 41);
        check("t3_ce_count", ce_cnt, 2);
        check("t3_first_low", first_low, 41);

        // Software disable held across a commit
        sw_disable_i = 1'b1;
        tick(); tick();
        check("t5_sw_disable", disable_o, 1);
        tick();
        exp_q.push_back(model_pack());
        commit_now();
        run_to(21);
        check("t5_ce_count", ce_cnt, 0);
        check("t5_first_low", first_low, 0);
        check("t5_done1", done1, 21);
        tick(); tick();
        sw_disable_i = 1'b0;
        tick();
        check("t5_sw_sampled", disable_o, 1);
        tick();
        check("t5_sw_low", disable_o, 0);
        check("t5_sw_ce", disable_ce_o, 1);
        tick();
        check("t5_sw_ce_end", disable_ce_o, 0);

        // Reset at edge 10 aborts the sequence
        write(0, 4'd0, 8'h42);
        commit_now();
        run_to(9);
        rst_i = 1'b1;
        tick();
        check("t6_disable", disable_o, 0);
        check("t6_ce", disable_ce_o, 0);
        check("t6_busy", busy_o, 0);
        check("t6_done", done_o, 0);
        check("t6_vectors", {pretrigger_vector_o, delay_vector_o}, 0);
        rst_i = 1'b0;
        model_reset();
        tick();
        write(0, 4'd0, 8'h5A);
        write(1, 4'd4, 8'h09);
        exp_q.push_back(model_pack());
        commit_now();
        tick();
        check("t6_e1_disable", disable_o, 1);
        check("t6_e1_busy", busy_o, 1);
        run_to(16);
        check("t6_e16_vectors", {pretrigger_vector_o, delay_vector_o}, 0);
        tick();
        check("t6_e17_vectors", {pretrigger_vector_o, delay_vector_o}, model_pack());
        run_to(21);
        check("t6_done1", done1, 21);
        check("t6_e21_busy", busy_o, 0);
        tick(); tick(); tick();
        check("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
